spi_rdid_master: RTL and testbench

- SPI mode-0 master that issues the JEDEC Read-Identification command (RDID, 0x9F) to an M25P16-class serial flash.
- Captures the 3-byte response: manufacturer 0x20, memory type 0x20, capacity 0x15.
- Sits between system logic, which pulses a request, and the flash pins.
- Exposes the captured ID fields as registered outputs.

---
 rtl/spi_rdid_pkg.sv | 26 ++
 rtl/spi_clk_gen.sv | 38 +++
 rtl/spi_rdid_master.sv | 144 ++++++++++++++
 tb/tb_spi_rdid_master.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rdid_pkg.sv
// Shared definitions for the SPI RDID master: command opcode, the expected
// M25P16 identification bytes, FSM state encoding and an ID-match helper.
package spi_rdid_pkg;

    localparam logic [7:0]  RDID_OPCODE         = 8'h9F;
    localparam int unsigned CMD_BITS            = 8;

    localparam logic [7:0]  EXP_MANUFACTURE_ID  = 8'h20;
    localparam logic [7:0]  EXP_MEMORY_TYPE     = 8'h20;
    localparam logic [7:0]  EXP_MEMORY_CAPACITY = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        DONE
    } state_t;

    // True when a captured 24-bit response is the M25P16 identification.
    function automatic logic id_is_m25p16(input logic [23:0] id);
        return id == {EXP_MANUFACTURE_ID, EXP_MEMORY_TYPE, EXP_MEMORY_CAPACITY};
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPICLK phase timer. Counts HALF_PERIOD clk cycles per SPICLK phase while
// enabled and flags the end of the current phase as a rise or fall strobe.
//   clk, reset : system clock, synchronous active-high reset
//   en         : phase counting enabled (FSM in LOW or HIGH)
//   sclk       : current SPICLK level, selects which strobe fires
//   rise_c     : end of low phase, SPICLK should go high this edge
//   fall_c     : end of high phase, SPICLK should go low this edge
module spi_clk_gen #(
    parameter int unsigned HALF_PERIOD = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sclk,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic             phase_end_c;

    assign phase_end_c = en && (cnt == CNT_LAST);
    assign rise_c      = phase_end_c && !sclk;
    assign fall_c      = phase_end_c && sclk;

    // Restart from zero on every phase boundary so each phase is a full HALF_PERIOD.
    always_ff @(posedge clk) begin
        if (reset || !en || phase_end_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_rdid_master.sv
// SPI mode-0 master issuing JEDEC RDID (0x9F) to an M25P16-class flash and
// capturing the 3-byte identification response.
//   clk, reset        : system clock, synchronous active-high reset
//   get_rdid          : start request, accepted only in IDLE
//   SPICLK/SPIMOSI    : serial clock (idles low) and master data out
//   SPIMISO           : slave data in, sampled on SPICLK rising edges
//   chip_select       : active-low flash select
//   read_data         : {manufacture_id, memory_type, memory_capacity}
//   busy / done       : transaction in progress / one-cycle completion pulse
// Optional: define SPI_RDID_ID_CHECK_EN to add id_valid, set at completion
// when the captured ID equals 24'h202015.
module spi_rdid_master
    import spi_rdid_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 1,
    parameter logic [7:0]  CMD_RDID    = RDID_OPCODE,
    parameter int unsigned RX_BITS     = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               get_rdid,
    output logic               SPICLK,
    output logic               SPIMOSI,
    input  logic               SPIMISO,
    output logic               chip_select,
    output logic [RX_BITS-1:0] read_data,
    output logic [7:0]         manufacture_id,
    output logic [7:0]         memory_type,
    output logic [7:0]         memory_capacity,
`ifdef SPI_RDID_ID_CHECK_EN
    output logic               id_valid,
`endif
    output logic               busy,
    output logic               done
);

    localparam int unsigned TOTAL_BITS = CMD_BITS + RX_BITS;
    localparam int unsigned IDX_W      = $clog2(TOTAL_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_BITS - 1);
    localparam logic [IDX_W-1:0] CMD_END  = IDX_W'(CMD_BITS);

    state_t           state;
    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] nxt_idx_c;
    logic [2:0]       cmd_sel_c;
    logic             clk_en_c;
    logic             rise_c;
    logic             fall_c;

    assign manufacture_id  = read_data[RX_BITS-1  -: 8];
    assign memory_type     = read_data[RX_BITS-9  -: 8];
    assign memory_capacity = read_data[RX_BITS-17 -: 8];

    assign clk_en_c  = (state == LOW) || (state == HIGH);
    assign nxt_idx_c = bit_idx + IDX_W'(1);
    // Command bits go out MSB first, so bit index n maps to CMD_RDID[7-n].
    assign cmd_sel_c = 3'(3'd7 - nxt_idx_c[2:0]);

    spi_clk_gen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_clk_gen (
        .clk    (clk),
        .reset  (reset),
        .en     (clk_en_c),
        .sclk   (SPICLK),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // Transaction sequencer with all pin and status outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_idx     <= '0;
            chip_select <= 1'b1;
            SPICLK      <= 1'b0;
            SPIMOSI     <= 1'b0;
            read_data   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef SPI_RDID_ID_CHECK_EN
            id_valid    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (get_rdid) begin
                        chip_select <= 1'b0;
                        busy        <= 1'b1;
                        bit_idx     <= '0;
`ifdef SPI_RDID_ID_CHECK_EN
                        id_valid    <= 1'b0;
`endif
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    SPIMOSI <= CMD_RDID[7];
                    state   <= LOW;
                end
                LOW: begin
                    if (rise_c) begin
                        SPICLK <= 1'b1;
                        // Response bits arrive MSB first; shift in at the LSB.
                        if (bit_idx >= CMD_END) begin
                            read_data <= {read_data[RX_BITS-2:0], SPIMISO};
                        end
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (fall_c) begin
                        SPICLK <= 1'b0;
                        if (bit_idx < LAST_IDX) begin
                            bit_idx <= nxt_idx_c;
                            SPIMOSI <= (nxt_idx_c < CMD_END) ? CMD_RDID[cmd_sel_c] : 1'b0;
                            state   <= LOW;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    chip_select <= 1'b1;
                    SPIMOSI     <= 1'b0;
                    done        <= 1'b1;
`ifdef SPI_RDID_ID_CHECK_EN
                    id_valid    <= id_is_m25p16(read_data[RX_BITS-1 -: 24]);
`endif
                    state       <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rdid_master.sv
// Bench for spi_rdid_master: two instances (HALF_PERIOD 1 and 3), each with a
// behavioural M25P16 RDID responder. Stimulus pushes expected results into a
// queue; a monitor pops and compares on every done pulse.
module tb_spi_rdid_master;

    localparam int unsigned NI        = 2;
    localparam logic [23:0] ID_M25P16 = 24'h202015;
    localparam logic [23:0] ID_OTHER  = 24'hEF4015;
    localparam logic [7:0]  CMD       = 8'h9F;

    typedef struct {
        int unsigned inst;
        logic [23:0] rd;
        logic        idv;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        get_rdid        [NI];
    logic        spiclk          [NI];
    logic        mosi            [NI];
    logic        miso            [NI];
    logic        cs              [NI];
    logic [23:0] read_data       [NI];
    logic [7:0]  mid             [NI];
    logic [7:0]  mtype           [NI];
    logic [7:0]  mcap            [NI];
    logic        busy            [NI];
    logic        done            [NI];
`ifdef SPI_RDID_ID_CHECK_EN
    logic        id_valid        [NI];
`endif
    logic [23:0] flash_id;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_rdid_master #(.HALF_PERIOD(1)) dut0 (
        .clk(clk), .reset(reset), .get_rdid(get_rdid[0]),
        .SPICLK(spiclk[0]), .SPIMOSI(mosi[0]), .SPIMISO(miso[0]),
        .chip_select(cs[0]), .read_data(read_data[0]),
        .manufacture_id(mid[0]), .memory_type(mtype[0]), .memory_capacity(mcap[0]),
`ifdef SPI_RDID_ID_CHECK_EN
        .id_valid(id_valid[0]),
`endif
        .busy(busy[0]), .done(done[0])
    );

    spi_rdid_master #(.HALF_PERIOD(3)) dut1 (
        .clk(clk), .reset(reset), .get_rdid(get_rdid[1]),
        .SPICLK(spiclk[1]), .SPIMOSI(mosi[1]), .SPIMISO(miso[1]),
        .chip_select(cs[1]), .read_data(read_data[1]),
        .manufacture_id(mid[1]), .memory_type(mtype[1]), .memory_capacity(mcap[1]),
`ifdef SPI_RDID_ID_CHECK_EN
        .id_valid(id_valid[1]),
`endif
        .busy(busy[1]), .done(done[1])
    );

    // Flash responder: after 8 command rises, drive flash_id MSB first on falling edges.
    for (genvar g = 0; g < NI; g++) begin : g_flash
        int unsigned nrise = 0;
        logic        drv   = 1'b0;
        always @(posedge spiclk[g] or posedge cs[g]) begin
            if (cs[g]) nrise <= 0;
            else       nrise <= nrise + 1;
        end
        always @(negedge spiclk[g] or posedge cs[g]) begin
            if (cs[g])                          drv <= 1'b0;
            else if (nrise >= 8 && nrise < 32)  drv <= flash_id[5'(31 - nrise)];
            else                                drv <= 1'b0;
        end
        assign miso[g] = drv;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
        end
    endtask

    // Monitor state, per instance.
    int unsigned cyc = 0;
    int unsigned m_rise     [NI];
    int unsigned m_last     [NI];
    int unsigned m_cs_bad   [NI];
    int unsigned m_mosi_bad [NI];
    int unsigned m_per_bad  [NI];
    int unsigned m_done_run [NI];
    logic [7:0]  m_cmd      [NI];
    logic [23:0] m_rd32     [NI];
    logic        prev_sclk  [NI];

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                m_rise[i] = 0; m_last[i] = 0; m_cs_bad[i] = 0; m_mosi_bad[i] = 0;
                m_per_bad[i] = 0; m_done_run[i] = 0; m_cmd[i] = '0; m_rd32[i] = '0;
                prev_sclk[i] = 1'b0;
            end else begin
                if (spiclk[i] && !prev_sclk[i]) begin
                    m_rise[i]++;
                    if (cs[i]) m_cs_bad[i]++;
                    if (m_rise[i] <= 8) m_cmd[i] = {m_cmd[i][6:0], mosi[i]};
                    else if (mosi[i]) m_mosi_bad[i]++;
                    if (m_rise[i] > 1 && (cyc - m_last[i]) != ((i == 0) ? 2 : 6)) m_per_bad[i]++;
                    m_last[i] = cyc;
                    if (m_rise[i] == 32) m_rd32[i] = read_data[i];
                end
                prev_sclk[i] = spiclk[i];

                if (done[i]) begin
                    if (m_done_run[i] == 0) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_done: inst %0d pulsed done, required no pulse", i);
                        end else begin
                            e = exp_q.pop_front();
                            chk("done_inst",       32'(i),            32'(e.inst));
                            chk("read_data",       32'(read_data[i]), 32'(e.rd));
                            chk("manufacture_id",  32'(mid[i]),       32'(e.rd[23:16]));
                            chk("memory_type",     32'(mtype[i]),     32'(e.rd[15:8]));
                            chk("memory_capacity", 32'(mcap[i]),      32'(e.rd[7:0]));
                            chk("read_data_at_last_rise", 32'(m_rd32[i]), 32'(e.rd));
                            chk("spiclk_rises",    32'(m_rise[i]),    32'd32);
                            chk("mosi_command",    32'(m_cmd[i]),     32'(CMD));
                            chk("cs_high_at_rise", 32'(m_cs_bad[i]),  32'd0);
                            chk("mosi_during_rx",  32'(m_mosi_bad[i]), 32'd0);
                            chk("spiclk_period",   32'(m_per_bad[i]), 32'd0);
`ifdef SPI_RDID_ID_CHECK_EN
                            chk("id_valid",        32'(id_valid[i]),  32'(e.idv));
`endif
                        end
                        m_rise[i] = 0; m_cs_bad[i] = 0; m_mosi_bad[i] = 0;
                        m_per_bad[i] = 0; m_cmd[i] = '0;
                    end
                    m_done_run[i]++;
                end else if (m_done_run[i] != 0) begin
                    chk("done_width", 32'(m_done_run[i]), 32'd1);
                    m_done_run[i] = 0;
                end
            end
        end
    end

    task automatic push(input int unsigned inst, input logic [23:0] rd, input logic idv);
        exp_t e;
        e.inst = inst; e.rd = rd; e.idv = idv;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input int unsigned i);
        get_rdid[i] = 1'b1;
        @(negedge clk);
        get_rdid[i] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_rise(input string name, input int unsigned i, input int unsigned n);
        int k = 0;
        while (m_rise[i] < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(m_rise[i] >= n), 32'd1);
    endtask

    task automatic check_idle(input string tag, input int unsigned i, input logic [23:0] rd);
        chk({tag, "_cs"},        32'(cs[i]),        32'd1);
        chk({tag, "_spiclk"},    32'(spiclk[i]),    32'd0);
        chk({tag, "_busy"},      32'(busy[i]),      32'd0);
        chk({tag, "_done"},      32'(done[i]),      32'd0);
        chk({tag, "_read_data"}, 32'(read_data[i]), 32'(rd));
    endtask

    initial begin
        int k;
        reset    = 1'b1;
        flash_id = ID_M25P16;
        for (int i = 0; i < NI; i++) get_rdid[i] = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check_idle("reset", i, 24'h0);
            chk("reset_mosi", 32'(mosi[i]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Single request.
        push(0, ID_M25P16, 1'b1);
        pulse(0);
        wait_drain("drain_single");
        repeat (20) @(negedge clk);
        check_idle("hold", 0, ID_M25P16);

        // Second request while busy must be ignored.
        push(0, ID_M25P16, 1'b1);
        pulse(0);
        wait_rise("rise5", 0, 5);
        pulse(0);
        wait_drain("drain_busy_ignore");
        repeat (100) @(negedge clk);
        check_idle("after_ignore", 0, ID_M25P16);

        // Reset at rise 12 aborts, then a fresh request completes.
        pulse(0);
        wait_rise("rise12", 0, 12);
        reset = 1'b1;
        @(negedge clk);
        check_idle("abort", 0, 24'h0);
        reset = 1'b0;
        @(negedge clk);
        push(0, ID_M25P16, 1'b1);
        pulse(0);
        wait_drain("drain_after_abort");

        // Level held across DONE starts a second transaction.
        push(0, ID_M25P16, 1'b1);
        push(0, ID_M25P16, 1'b1);
        get_rdid[0] = 1'b1;
        k = 0;
        while (exp_q.size() != 1 && k < 1000) begin @(negedge clk); k++; end
        while (busy[0] && k < 2000) begin @(negedge clk); k++; end
        while (!busy[0] && k < 3000) begin @(negedge clk); k++; end
        chk("level_restart_busy", 32'(busy[0]), 32'd1);
        get_rdid[0] = 1'b0;
        wait_drain("drain_level_held");

        // HALF_PERIOD=3 instance.
        push(1, ID_M25P16, 1'b1);
        pulse(1);
        wait_drain("drain_hp3");
        check_idle("hp3_end", 1, ID_M25P16);

`ifdef SPI_RDID_ID_CHECK_EN
        // Foreign ID must leave id_valid low.
        flash_id = ID_OTHER;
        push(0, ID_OTHER, 1'b0);
        pulse(0);
        wait_drain("drain_other_id");
`endif

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
